// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-index width, FSM states, inverse S-box
// and GF(2^8) helpers used by the inverse round datapath.
package aes_pkg;

    localparam int NR     = 14;
    localparam int KIDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplier constants of InvMixColumns (0x09..0x0e) all fit in four bits.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] x;
        logic [3:0] k;
        p = 8'h00;
        x = a;
        k = m;
        for (int i = 0; i < 4; i++) begin
            if (k[0]) p = p ^ x;
            x = xtime(x);
            k = k >> 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round_fun.sv
// One AES inverse round, purely combinational:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when inLast=1).
module aes_inv_round_fun
    import aes_pkg::*;
(
    input  logic [127:0] inData,
    input  logic [127:0] inKey,
    input  logic         inLast,
    output logic [127:0] outData
);

    // Byte i of the block is (row i%4, column i/4) and sits at [127-8i -: 8].
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] ark;
        logic [31:0] mix;

        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = ((c - r + 4) % 4) * 4 + r;
            localparam int DST = c * 4 + r;
            assign ark[31-8*r -: 8] = inv_sbox(inData[127-8*SRC -: 8]) ^ inKey[127-8*DST -: 8];
        end

        assign mix[31:24] = gf_mul(ark[31:24], 4'he) ^ gf_mul(ark[23:16], 4'hb) ^
                            gf_mul(ark[15:8],  4'hd) ^ gf_mul(ark[7:0],   4'h9);
        assign mix[23:16] = gf_mul(ark[31:24], 4'h9) ^ gf_mul(ark[23:16], 4'he) ^
                            gf_mul(ark[15:8],  4'hb) ^ gf_mul(ark[7:0],   4'hd);
        assign mix[15:8]  = gf_mul(ark[31:24], 4'hd) ^ gf_mul(ark[23:16], 4'h9) ^
                            gf_mul(ark[15:8],  4'he) ^ gf_mul(ark[7:0],   4'hb);
        assign mix[7:0]   = gf_mul(ark[31:24], 4'hb) ^ gf_mul(ark[23:16], 4'hd) ^
                            gf_mul(ark[15:8],  4'h9) ^ gf_mul(ark[7:0],   4'he);

        assign outData[127-32*c -: 32] = inLast ? ark : mix;
    end

endmodule

// File: rtl/aes_dec_round_iter.sv
// Iterative AES-256 decryptor, one inverse round per clock with keys fetched by index.
// Optional AES_DEC_ZEROIZE_EN: clears the state after delivery and masks outData while idle.
module aes_dec_round_iter
    import aes_pkg::*;
(
    input  logic              inClk,
    input  logic              inRst,
    input  logic              inValid,
    output logic              outReady,
    input  logic [127:0]      inData,
    output logic [KIDX_W-1:0] outKeyIdx,
    input  logic [127:0]      inKey,
    output logic              outValid,
    input  logic              inReady,
    output logic [127:0]      outData
);

    fsm_t              fsm;
    logic [KIDX_W-1:0] cnt;
    logic [127:0]      state;
    logic [127:0]      round_out;
    logic              last_round;

    assign last_round = (cnt == '0);

    aes_inv_round_fun u_round (
        .inData  (state),
        .inKey   (inKey),
        .inLast  (last_round),
        .outData (round_out)
    );

    // NOTE: reset is tested first inside the clocked block so it overrides every transition.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            fsm   <= IDLE;
            cnt   <= '0;
            state <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (inValid) begin
                        state <= inData ^ inKey;
                        cnt   <= KIDX_W'(NR - 1);
                        fsm   <= ROUND;
                    end
`ifdef AES_DEC_ZEROIZE_EN
                    else begin
                        state <= '0;
                    end
`endif
                end
                ROUND: begin
                    state <= round_out;
                    if (last_round) fsm <= DONE;
                    else            cnt <= cnt - 1'b1;
                end
                DONE: begin
                    if (inReady) begin
                        fsm <= IDLE;
`ifdef AES_DEC_ZEROIZE_EN
                        state <= '0;
`endif
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Ready is masked by reset so nothing is offered while the block is held in reset.
    assign outReady  = (fsm == IDLE) && !inRst;
    assign outValid  = (fsm == DONE);
    assign outKeyIdx = (fsm == ROUND) ? cnt : KIDX_W'(NR);

`ifdef AES_DEC_ZEROIZE_EN
    assign outData = outValid ? state : '0;
`else
    assign outData = state;
`endif

endmodule

// File: tb/tb_aes_dec_round_iter.sv
// Directed bench for aes_dec_round_iter; expected plaintexts come from a forward AES-256
// model whose S-box is derived arithmetically from GF(2^8) inversion and the affine map.
module tb_aes_dec_round_iter;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         in_rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;
    logic [3:0]   out_key_idx;
    logic [127:0] in_key;
    logic         out_valid;
    logic         in_ready;
    logic [127:0] out_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk_mem [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference key store answers the requested index in the same cycle.
    assign in_key = rk_mem[out_key_idx];

    aes_dec_round_iter dut (
        .inClk     (clk),
        .inRst     (in_rst),
        .inValid   (in_valid),
        .outReady  (out_ready),
        .inData    (in_data),
        .outKeyIdx (out_key_idx),
        .inKey     (in_key),
        .outValid  (out_valid),
        .inReady   (in_ready),
        .outData   (out_data)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = 32'(key >> (32 * (7 - i)));
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk_mem[15] = '0;
    endtask

    function automatic logic [127:0] enc_round(input logic [127:0] v, input logic [127:0] k, input bit last);
        logic [7:0]   a [16];
        logic [7:0]   s [16];
        logic [7:0]   m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = 8'(v >> (8 * (15 - i)));
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[c*4+r] = sbox[a[((c + r) % 4) * 4 + r]];
        for (int c = 0; c < 4; c++) begin
            m[c*4+0] = xt(s[c*4+0]) ^ xt(s[c*4+1]) ^ s[c*4+1] ^ s[c*4+2] ^ s[c*4+3];
            m[c*4+1] = s[c*4+0] ^ xt(s[c*4+1]) ^ xt(s[c*4+2]) ^ s[c*4+2] ^ s[c*4+3];
            m[c*4+2] = s[c*4+0] ^ s[c*4+1] ^ xt(s[c*4+2]) ^ xt(s[c*4+3]) ^ s[c*4+3];
            m[c*4+3] = xt(s[c*4+0]) ^ s[c*4+0] ^ s[c*4+1] ^ s[c*4+2] ^ xt(s[c*4+3]);
        end
        o = '0;
        for (int i = 0; i < 16; i++) o = {o[119:0], (last ? s[i] : m[i])};
        return o ^ k;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_mem[0];
        for (int r = 1; r < 14; r++) s = enc_round(s, rk_mem[r], 1'b0);
        return enc_round(s, rk_mem[14], 1'b1);
    endfunction

    // Called at a negedge with inValid already driven; returns in the accept cycle.
    task automatic wait_ready(output int t);
        t = -1;
        for (int n = 0; n < 40; n++) begin
            if (out_ready === 1'b1) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: outReady never rose within 40 cycles");
        end
    endtask

    // Called at a negedge after the accept edge; returns in the first outValid cycle.
    task automatic wait_valid(output int t);
        t = -1;
        for (int n = 0; n < 40; n++) begin
            if (out_valid === 1'b1) begin
                t = cyc;
                break;
            end
            checks++;
            if (out_ready !== 1'b0) begin
                failures++;
                $display("FAIL busy_ready: outReady=%b while busy, expected 0", out_ready);
            end
`ifdef AES_DEC_ZEROIZE_EN
            checks++;
            if (out_data !== 128'h0) begin
                failures++;
                $display("FAIL zeroize_busy: outData=%h while outValid=0, expected 0", out_data);
            end
`endif
            @(negedge clk);
        end
        if (t < 0) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: outValid never rose within 40 cycles");
        end
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt);
        int ta;
        int tv;
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = ct;
        wait_ready(ta);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(tv);
        checks++;
        if (tv - ta != 15) begin
            failures++;
            $display("FAIL latency: got %0d cycles, expected 15", tv - ta);
        end
        checks++;
        if (out_data !== pt) begin
            failures++;
            $display("FAIL plaintext: got %h expected %h (ct %h)", out_data, pt, ct);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_handshake: valid=%b ready=%b, expected valid=0 ready=1", out_valid, out_ready);
        end
        checks++;
`ifdef AES_DEC_ZEROIZE_EN
        if (out_data !== 128'h0) begin
            failures++;
            $display("FAIL zeroize_idle: outData=%h, expected 0", out_data);
        end
`else
        if (out_data !== pt) begin
            failures++;
            $display("FAIL hold_idle: outData=%h, expected held %h", out_data, pt);
        end
`endif
    endtask

    task automatic test_reset();
        in_rst   = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        in_data  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 128'h0) begin
            failures++;
            $display("FAIL reset_hold: ready=%b valid=%b data=%h, expected 0/0/0", out_ready, out_valid, out_data);
        end
        in_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_ready !== 1'b1 || out_valid !== 1'b0 || out_key_idx !== 4'd14 || out_data !== 128'h0) begin
            failures++;
            $display("FAIL reset_release: ready=%b valid=%b idx=%0d data=%h, expected 1/0/14/0",
                     out_ready, out_valid, out_key_idx, out_data);
        end
    endtask

    task automatic test_c3_vector();
        int ta;
        load_key(C3_KEY);
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = C3_CT;
        wait_ready(ta);
        checks++;
        if (out_key_idx !== 4'd14) begin
            failures++;
            $display("FAIL key_idx_idle: got %0d expected 14", out_key_idx);
        end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            checks++;
            if (k <= 14) begin
                if (out_key_idx !== 4'(14 - k) || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL key_trace: cycle +%0d idx=%0d valid=%b, expected idx=%0d valid=0",
                             k, out_key_idx, out_valid, 14 - k);
                end
            end else begin
                if (out_valid !== 1'b1 || out_data !== C3_PT) begin
                    failures++;
                    $display("FAIL c3_result: valid=%b data=%h, expected valid=1 data=%h", out_valid, out_data, C3_PT);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
            failures++;
            $display("FAIL c3_handshake: valid=%b ready=%b, expected 0/1", out_valid, out_ready);
        end
    endtask

    task automatic test_backpressure();
        int ta;
        int tv;
        load_key(C3_KEY);
        in_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = C3_CT;
        wait_ready(ta);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(tv);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_ready !== 1'b0 || out_data !== C3_PT) begin
                failures++;
                $display("FAIL backpressure: cycle %0d valid=%b ready=%b data=%h, expected 1/0/%h",
                         i, out_valid, out_ready, out_data, C3_PT);
            end
            @(negedge clk);
        end
        in_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: valid=%b ready=%b, expected 0/1", out_valid, out_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_single: outValid=%b after handshake, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int tv;
        logic [127:0] pt2;
        logic [127:0] ct2;
        load_key(C3_KEY);
        pt2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        ct2 = encrypt(pt2);
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = C3_CT;
        wait_ready(t1);
        @(negedge clk);
        in_data = ct2;
        wait_valid(tv);
        checks++;
        if (out_data !== C3_PT) begin
            failures++;
            $display("FAIL b2b_first: got %h expected %h", out_data, C3_PT);
        end
        @(negedge clk);
        wait_ready(t2);
        checks++;
        if (t2 - t1 != 16) begin
            failures++;
            $display("FAIL b2b_spacing: accepts %0d cycles apart, expected 16", t2 - t1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(tv);
        checks++;
        if (out_data !== pt2) begin
            failures++;
            $display("FAIL b2b_second: got %h expected %h", out_data, pt2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ta;
        load_key(C3_KEY);
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = C3_CT;
        wait_ready(ta);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (out_key_idx !== 4'd7) begin
            failures++;
            $display("FAIL mid_idx: got %0d expected 7", out_key_idx);
        end
        in_rst = 1'b1;
        @(negedge clk);
        in_rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_key_idx !== 4'd14) begin
            failures++;
            $display("FAIL mid_reset: valid=%b ready=%b idx=%0d, expected 0/1/14", out_valid, out_ready, out_key_idx);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_output: outValid=%b at cycle %0d after reset, expected 0", out_valid, i);
            end
        end
    endtask

    task automatic test_sweep();
        logic [255:0] key;
        logic [127:0] pt;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_key(key);
            run_block(encrypt(pt), pt);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_c3_vector();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
